// File: rtl/idu_pkg.sv
// Shared types and helpers for the IDU instruction queue: entry layout, default
// geometry and the thermometer lane counter used on both enqueue and dispatch.
package idu_pkg;

    localparam int IBUF_DEPTH  = 8;
    localparam int IBUF_INST_W = 32;
    localparam int IBUF_PC_W   = 32;
    localparam int PTR_W       = $clog2(IBUF_DEPTH);
    localparam int MAX_LANES   = 4;

    typedef struct packed {
        logic [IBUF_INST_W-1:0] inst;
        logic [IBUF_PC_W-1:0]   pc;
        logic                   unalign_pc;
    } ibuf_entry_t;

    // Counts consecutive ones starting at bit 0; anything past the first zero is ignored.
    function automatic logic [2:0] lead_ones(input logic [MAX_LANES-1:0] v);
        logic [2:0] n;
        logic       stop;
        n    = 3'd0;
        stop = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (!v[i]) begin
                stop = 1'b1;
            end else if (!stop) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/idu_inst_queue_ram.sv
// Entry storage for the instruction queue: multi-port write, combinational
// multi-port read, no reset on the array.
module idu_inst_queue_ram #(
    parameter int DEPTH    = 8,
    parameter int ENTRY_W  = 65,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2
) (
    input  logic                                 clk,
    input  logic [WR_PORTS-1:0]                  we_i,
    input  logic [WR_PORTS*$clog2(DEPTH)-1:0]    waddr_i,
    input  logic [WR_PORTS*ENTRY_W-1:0]          wdata_i,
    input  logic [RD_PORTS*$clog2(DEPTH)-1:0]    raddr_i,
    output logic [RD_PORTS*ENTRY_W-1:0]          rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write addresses within one cycle are always distinct, so port order does not matter.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WR_PORTS; k++) begin
            if (we_i[k]) begin
                mem[waddr_i[k*AW +: AW]] <= wdata_i[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
            rdata_o[j*ENTRY_W +: ENTRY_W] = mem[raddr_i[j*AW +: AW]];
        end
    end

endmodule

// File: rtl/idu_inst_queue.sv
// IDU instruction queue: circular multi-lane FIFO between IFU fetch and the dispatcher.
// Optional stall counters are enabled by defining IDU_INST_QUEUE_STALL_CNT_EN.
module idu_inst_queue
    import idu_pkg::*;
#(
    parameter int DEPTH      = IBUF_DEPTH,
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2,
    parameter int INST_WIDTH = IBUF_INST_W,
    parameter int PC_WIDTH   = IBUF_PC_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sync_start_pulse,
    input  logic                            bru_flush,
    input  logic                            dispatcher_detect_exceptions_wfi,
    input  logic [ENQ_WIDTH-1:0]            ifu_idu_fetch_vld,
    input  logic [ENQ_WIDTH*INST_WIDTH-1:0] inst_in,
    input  logic [ENQ_WIDTH*PC_WIDTH-1:0]   pc_in,
    input  logic [ENQ_WIDTH-1:0]            unalign_pc_in,
    output logic                            idu_ifu_instBuffer_full,
    input  logic [DEQ_WIDTH-1:0]            dispatch_vld,
    output logic [DEQ_WIDTH-1:0]            inst_vld,
    output logic [DEQ_WIDTH*INST_WIDTH-1:0] inst_out,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]   pc_out,
    output logic [DEQ_WIDTH-1:0]            unalign_pc_out,
    output logic [$clog2(DEPTH):0]          occupancy
`ifdef IDU_INST_QUEUE_STALL_CNT_EN
   ,output logic [31:0]                     full_cycles,
    output logic [31:0]                     empty_dispatch_cycles
`endif
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int ENTRY_W  = INST_WIDTH + PC_WIDTH + 1;

    logic [PTR_BITS-1:0]           wrPtr_q, wrPtr_d;
    logic [PTR_BITS-1:0]           rdPtr_q, rdPtr_d;
    logic [CNT_BITS-1:0]           count_q, count_d;
    logic                          full_q, full_d;
    logic                          flush;
    logic [MAX_LANES-1:0]          fetchExt;
    logic [MAX_LANES-1:0]          popExt;
    logic [2:0]                    nPush;
    logic [2:0]                    nPop;
    logic [ENQ_WIDTH-1:0]          wrEn;
    logic [ENQ_WIDTH*PTR_BITS-1:0] wrAddr;
    logic [ENQ_WIDTH*ENTRY_W-1:0]  wrData;
    logic [DEQ_WIDTH*PTR_BITS-1:0] rdAddr;
    logic [DEQ_WIDTH*ENTRY_W-1:0]  rdData;

    assign flush = sync_start_pulse | bru_flush | dispatcher_detect_exceptions_wfi;

    always_comb begin
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            inst_vld[j] = (count_q > CNT_BITS'(j));
        end
    end

    // Only the thermometer prefix of each request counts; full_q blocks the whole fetch group.
    always_comb begin
        fetchExt                  = '0;
        fetchExt[ENQ_WIDTH-1:0]   = ifu_idu_fetch_vld;
        popExt                    = '0;
        popExt[DEQ_WIDTH-1:0]     = dispatch_vld & inst_vld;
        nPush                     = full_q ? 3'd0 : lead_ones(fetchExt);
        nPop                      = lead_ones(popExt);
    end

    always_comb begin
        wrPtr_d = wrPtr_q + PTR_BITS'(nPush);
        rdPtr_d = rdPtr_q + PTR_BITS'(nPop);
        count_d = count_q + CNT_BITS'(nPush) - CNT_BITS'(nPop);
        full_d  = (DEPTH - int'(count_d)) < ENQ_WIDTH;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        wrEn   = '0;
        wrAddr = '0;
        wrData = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            wrEn[k]                          = (k < int'(nPush)) && !flush && !rst;
            wrAddr[k*PTR_BITS +: PTR_BITS]   = wrPtr_q + PTR_BITS'(k);
            wrData[k*ENTRY_W +: ENTRY_W]     = {unalign_pc_in[k],
                                                pc_in[k*PC_WIDTH +: PC_WIDTH],
                                                inst_in[k*INST_WIDTH +: INST_WIDTH]};
        end
    end

    always_comb begin
        rdAddr = '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            rdAddr[j*PTR_BITS +: PTR_BITS] = rdPtr_q + PTR_BITS'(j);
        end
    end

    idu_inst_queue_ram #(
        .DEPTH    (DEPTH),
        .ENTRY_W  (ENTRY_W),
        .WR_PORTS (ENQ_WIDTH),
        .RD_PORTS (DEQ_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wrEn),
        .waddr_i (wrAddr),
        .wdata_i (wrData),
        .raddr_i (rdAddr),
        .rdata_o (rdData)
    );

    always_comb begin
        inst_out       = '0;
        pc_out         = '0;
        unalign_pc_out = '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            inst_out[j*INST_WIDTH +: INST_WIDTH] = rdData[j*ENTRY_W +: INST_WIDTH];
            pc_out[j*PC_WIDTH +: PC_WIDTH]       = rdData[j*ENTRY_W + INST_WIDTH +: PC_WIDTH];
            unalign_pc_out[j]                    = rdData[j*ENTRY_W + INST_WIDTH + PC_WIDTH];
        end
    end

    assign occupancy               = count_q;
    assign idu_ifu_instBuffer_full = full_q;

`ifdef IDU_INST_QUEUE_STALL_CNT_EN
    logic [31:0] fullCycles_q;
    logic [31:0] emptyCycles_q;

    // A branch redirect is a normal event, so only reset and core start clear the statistics.
    always_ff @(posedge clk) begin
        if (rst || sync_start_pulse) begin
            fullCycles_q  <= '0;
            emptyCycles_q <= '0;
        end else begin
            if (full_q && (fullCycles_q != 32'hFFFF_FFFF)) begin
                fullCycles_q <= fullCycles_q + 32'd1;
            end
            if ((count_q == '0) && (emptyCycles_q != 32'hFFFF_FFFF)) begin
                emptyCycles_q <= emptyCycles_q + 32'd1;
            end
        end
    end

    assign full_cycles           = fullCycles_q;
    assign empty_dispatch_cycles = emptyCycles_q;
`endif

`ifndef SYNTHESIS
    logic [ENQ_WIDTH-1:0] fetchInc;
    logic [DEQ_WIDTH-1:0] dispInc;

    always_comb begin
        fetchInc = ifu_idu_fetch_vld + ENQ_WIDTH'(1);
        dispInc  = dispatch_vld + DEQ_WIDTH'(1);
    end

    assert property (@(posedge clk) disable iff (rst) count_q <= CNT_BITS'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) !(full_q && (wrEn != '0)));
    assert property (@(posedge clk) disable iff (rst) (fetchInc & ifu_idu_fetch_vld) == '0);
    assert property (@(posedge clk) disable iff (rst) (dispInc & dispatch_vld) == '0);
`endif

endmodule

// File: tb/tb_idu_inst_queue.sv
// Self-checking bench for idu_inst_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_idu_inst_queue;
    import idu_pkg::*;

    localparam int DEPTH = 1 << PTR_W;
    localparam int ENQ   = 2;
    localparam int DEQ   = 2;
    localparam int IW    = IBUF_INST_W;
    localparam int PW    = IBUF_PC_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              sync_start_pulse;
    logic              bru_flush;
    logic              dispatcher_detect_exceptions_wfi;
    logic [ENQ-1:0]    ifu_idu_fetch_vld;
    logic [ENQ*IW-1:0] inst_in;
    logic [ENQ*PW-1:0] pc_in;
    logic [ENQ-1:0]    unalign_pc_in;
    logic              idu_ifu_instBuffer_full;
    logic [DEQ-1:0]    dispatch_vld;
    logic [DEQ-1:0]    inst_vld;
    logic [DEQ*IW-1:0] inst_out;
    logic [DEQ*PW-1:0] pc_out;
    logic [DEQ-1:0]    unalign_pc_out;
    logic [CW-1:0]     occupancy;
`ifdef IDU_INST_QUEUE_STALL_CNT_EN
    logic [31:0]       full_cycles;
    logic [31:0]       empty_dispatch_cycles;
`endif

    idu_inst_queue #(
        .DEPTH      (DEPTH),
        .ENQ_WIDTH  (ENQ),
        .DEQ_WIDTH  (DEQ),
        .INST_WIDTH (IW),
        .PC_WIDTH   (PW)
    ) dut (
        .clk                              (clk),
        .rst                              (rst),
        .sync_start_pulse                 (sync_start_pulse),
        .bru_flush                        (bru_flush),
        .dispatcher_detect_exceptions_wfi (dispatcher_detect_exceptions_wfi),
        .ifu_idu_fetch_vld                (ifu_idu_fetch_vld),
        .inst_in                          (inst_in),
        .pc_in                            (pc_in),
        .unalign_pc_in                    (unalign_pc_in),
        .idu_ifu_instBuffer_full          (idu_ifu_instBuffer_full),
        .dispatch_vld                     (dispatch_vld),
        .inst_vld                         (inst_vld),
        .inst_out                         (inst_out),
        .pc_out                           (pc_out),
        .unalign_pc_out                   (unalign_pc_out),
        .occupancy                        (occupancy)
`ifdef IDU_INST_QUEUE_STALL_CNT_EN
       ,.full_cycles                      (full_cycles),
        .empty_dispatch_cycles            (empty_dispatch_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ibuf_entry_t modelQ[$];
    bit          modelFull;
    int unsigned modelFullCyc;
    int unsigned modelEmptyCyc;
    int          assertCount;
    int          failCount;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares every visible output against the reference queue.
    task automatic checkAll(input string phase);
        checkOutput({phase, "_occupancy"}, 64'(occupancy), 64'(modelQ.size()));
        checkOutput({phase, "_full"}, 64'(idu_ifu_instBuffer_full), 64'(modelFull));
        for (int j = 0; j < DEQ; j++) begin
            checkOutput($sformatf("%s_vld%0d", phase, j), 64'(inst_vld[j]), 64'(j < modelQ.size()));
            if (j < modelQ.size()) begin
                checkOutput($sformatf("%s_inst%0d", phase, j), 64'(inst_out[j*IW +: IW]), 64'(modelQ[j].inst));
                checkOutput($sformatf("%s_pc%0d", phase, j), 64'(pc_out[j*PW +: PW]), 64'(modelQ[j].pc));
                checkOutput($sformatf("%s_ua%0d", phase, j), 64'(unalign_pc_out[j]), 64'(modelQ[j].unalign_pc));
            end
        end
`ifdef IDU_INST_QUEUE_STALL_CNT_EN
        checkOutput({phase, "_fullCycles"}, 64'(full_cycles), 64'(modelFullCyc));
        checkOutput({phase, "_emptyCycles"}, 64'(empty_dispatch_cycles), 64'(modelEmptyCyc));
`endif
    endtask

    // Drives one cycle of inputs, advances the reference model and waits past the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit b, input bit e,
                                 input int nFetch, input logic [PW-1:0] basePc, input int nDisp);
        ibuf_entry_t lane[ENQ];
        int          pushN;
        int          popN;
        rst                              = r;
        sync_start_pulse                 = s;
        bru_flush                        = b;
        dispatcher_detect_exceptions_wfi = e;
        for (int k = 0; k < ENQ; k++) begin
            lane[k].inst               = IW'($urandom);
            lane[k].pc                 = basePc + PW'(4 * k);
            lane[k].unalign_pc         = 1'($urandom_range(0, 1));
            ifu_idu_fetch_vld[k]       = (k < nFetch);
            inst_in[k*IW +: IW]        = lane[k].inst;
            pc_in[k*PW +: PW]          = lane[k].pc;
            unalign_pc_in[k]           = lane[k].unalign_pc;
        end
        for (int j = 0; j < DEQ; j++) begin
            dispatch_vld[j] = (j < nDisp);
        end

        if (r || s) begin
            modelFullCyc  = 0;
            modelEmptyCyc = 0;
        end else begin
            if (modelFull && modelFullCyc != 32'hFFFF_FFFF) modelFullCyc++;
            if (modelQ.size() == 0 && modelEmptyCyc != 32'hFFFF_FFFF) modelEmptyCyc++;
        end

        if (r || s || b || e) begin
            modelQ.delete();
            modelFull = 1'b0;
        end else begin
            pushN = modelFull ? 0 : nFetch;
            popN  = (nDisp < modelQ.size()) ? nDisp : modelQ.size();
            for (int j = 0; j < popN; j++) void'(modelQ.pop_front());
            for (int k = 0; k < pushN; k++) modelQ.push_back(lane[k]);
            modelFull = (DEPTH - modelQ.size()) < ENQ;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        int nF;
        int nD;
        int roll;
        assertCount = 0;
        failCount   = 0;
        modelFull   = 1'b0;
        modelFullCyc  = 0;
        modelEmptyCyc = 0;
        rst = 1'b1;
        sync_start_pulse = 1'b0;
        bru_flush = 1'b0;
        dispatcher_detect_exceptions_wfi = 1'b0;
        ifu_idu_fetch_vld = '0;
        inst_in = '0;
        pc_in = '0;
        unalign_pc_in = '0;
        dispatch_vld = '0;

        doReset();
        doReset();
        checkAll("reset");

        applyStimulus(0, 0, 0, 0, 2, 32'h10, 0);
        checkAll("t1");
        checkOutput("t1_pc0_const", 64'(pc_out[PW-1:0]), 64'h10);
        checkOutput("t1_pc1_const", 64'(pc_out[2*PW-1:PW]), 64'h14);
        checkOutput("t1_occ_const", 64'(occupancy), 64'd2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
            checkAll("t2_fill");
        end
        checkOutput("t2_full_const", 64'(idu_ifu_instBuffer_full), 64'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
            checkAll("t2_hold");
        end
        checkOutput("t2_occ_const", 64'(occupancy), 64'd8);

        applyStimulus(0, 0, 0, 0, 0, '0, 1);
        checkAll("t3_pop1");
        checkOutput("t3_occ7", 64'(occupancy), 64'd7);
        checkOutput("t3_full_hi", 64'(idu_ifu_instBuffer_full), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, '0, 2);
        checkAll("t3_pop2");
        checkOutput("t3_occ5", 64'(occupancy), 64'd5);
        checkOutput("t3_full_lo", 64'(idu_ifu_instBuffer_full), 64'd0);

        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, '0, 2);
        checkAll("t4_empty");
        applyStimulus(0, 0, 0, 0, 2, 32'h100, 0);
        applyStimulus(0, 0, 0, 0, 2, 32'h108, 0);
        checkAll("t4_wrap");
        checkOutput("t4_pc0", 64'(pc_out[PW-1:0]), 64'h100);
        checkOutput("t4_pc1", 64'(pc_out[2*PW-1:PW]), 64'h104);
        applyStimulus(0, 0, 0, 0, 0, '0, 2);
        checkAll("t4_wrap2");
        checkOutput("t4_pc2", 64'(pc_out[PW-1:0]), 64'h108);
        checkOutput("t4_pc3", 64'(pc_out[2*PW-1:PW]), 64'h10C);

        for (int f = 0; f < 3; f++) begin
            doReset();
            applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
            applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
            applyStimulus(0, 0, 0, 0, 1, PW'($urandom), 0);
            checkOutput($sformatf("t5_pre_occ%0d", f), 64'(occupancy), 64'd5);
            applyStimulus(0, f == 2, f == 0, f == 1, 2, PW'($urandom), 1);
            checkAll($sformatf("t5_flush%0d", f));
            checkOutput($sformatf("t5_occ%0d", f), 64'(occupancy), 64'd0);
            checkOutput($sformatf("t5_vld%0d", f), 64'(inst_vld), 64'd0);
        end

        doReset();
        applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
        applyStimulus(0, 0, 0, 0, 2, PW'($urandom), 0);
        applyStimulus(1, 0, 0, 0, 2, PW'($urandom), 1);
        checkAll("t6");
        checkOutput("t6_occ", 64'(occupancy), 64'd0);
`ifdef IDU_INST_QUEUE_STALL_CNT_EN
        checkOutput("t6_fullCycles", 64'(full_cycles), 64'd0);
        checkOutput("t6_emptyCycles", 64'(empty_dispatch_cycles), 64'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            roll = int'($urandom_range(0, 199));
            nF   = int'($urandom_range(0, ENQ));
            nD   = int'($urandom_range(0, DEQ));
            applyStimulus(roll == 0, roll == 1, roll inside {[2:4]}, roll inside {[5:6]},
                          nF, PW'($urandom), nD);
            checkAll("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
